// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared types and constants for the shared "101" detector scheduler
package seq_det_pkg;

    localparam int PAT_LEN = 3;

    typedef enum logic [$clog2(PAT_LEN)-1:0] {
        DS_S0,
        DS_S1,
        DS_S2
    } det_state_t;

    typedef enum logic [1:0] {
        C_IDLE,
        C_STREAM,
        C_DONE
    } ctrl_state_t;

endpackage

// File: rtl/seq_det_core.sv
// rtl/seq_det_core.sv - serial "101" Mealy detector, advancing only on enabled bits
module seq_det_core
    import seq_det_pkg::*;
#(
    parameter int OVERLAP = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic din,
    output logic match
);

    det_state_t state;

    // Mealy output: the accepted bit itself completes the pattern.
    assign match = en && din && (state == DS_S2);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state <= DS_S0;
        end else if (en) begin
            case (state)
                DS_S0:   state <= din ? DS_S1 : DS_S0;
                DS_S1:   state <= din ? DS_S1 : DS_S2;
                DS_S2:   state <= (din && (OVERLAP != 0)) ? DS_S1 : DS_S0;
                default: state <= DS_S0;
            endcase
        end
    end

endmodule

// File: rtl/seq_det_sched.sv
// rtl/seq_det_sched.sv - round-robin frame scheduler sharing one detector core across lanes
module seq_det_sched
    import seq_det_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 8,
    parameter int OVERLAP = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         bit_vld,
    input  logic [NUM_REQ-1:0]         bit_in,
    input  logic [NUM_REQ-1:0]         bit_last,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       bit_rdy,
    output logic                       det,
    output logic                       done,
    output logic [$clog2(NUM_REQ)-1:0] done_ch,
    output logic [CNT_W-1:0]           done_cnt,
    output logic                       done_abort,
    output logic                       busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    ctrl_state_t      state;
    logic [IDX_W-1:0] g;
    logic [IDX_W-1:0] ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] cnt_next;
    logic [IDX_W-1:0] pick;
    logic             pick_found;
    logic [IDX_W:0]   sum;
    logic             accept;
    logic             match;

    assign accept = bit_rdy && bit_vld[g];

    seq_det_core #(
        .OVERLAP (OVERLAP)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .clr   (state == C_DONE),
        .en    (accept),
        .din   (bit_in[g]),
        .match (match)
    );

    // Circular search for the first requester at or after the pointer.
    always_comb begin
        pick       = ptr;
        pick_found = 1'b0;
        sum        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr} + (IDX_W + 1)'(i);
            if (sum >= NUM_REQ_W) begin
                sum = sum - NUM_REQ_W;
            end
            if (!pick_found && req[sum[IDX_W-1:0]]) begin
                pick       = sum[IDX_W-1:0];
                pick_found = 1'b1;
            end
        end
    end

    always_comb begin
        cnt_next = count;
        if (match && (count != {CNT_W{1'b1}})) begin
            cnt_next = count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= C_IDLE;
            g          <= '0;
            ptr        <= '0;
            count      <= '0;
            gnt        <= '0;
            bit_rdy    <= 1'b0;
            det        <= 1'b0;
            done       <= 1'b0;
            done_ch    <= '0;
            done_cnt   <= '0;
            done_abort <= 1'b0;
            busy       <= 1'b0;
        end else begin
            det  <= 1'b0;
            done <= 1'b0;
            case (state)
                C_IDLE: begin
                    if (|req) begin
                        g       <= pick;
                        gnt     <= ONE_HOT0 << pick;
                        bit_rdy <= 1'b1;
                        busy    <= 1'b1;
                        state   <= C_STREAM;
                    end
                end
                C_STREAM: begin
                    det   <= match;
                    count <= cnt_next;
                    // bit_last outranks a simultaneous request drop.
                    if ((accept && bit_last[g]) || !req[g]) begin
                        gnt        <= '0;
                        bit_rdy    <= 1'b0;
                        done       <= 1'b1;
                        done_ch    <= g;
                        done_cnt   <= cnt_next;
                        done_abort <= !(accept && bit_last[g]);
                        state      <= C_DONE;
                    end
                end
                C_DONE: begin
                    count <= '0;
                    ptr   <= (g == LAST_IDX) ? '0 : g + 1'b1;
                    busy  <= 1'b0;
                    state <= C_IDLE;
                end
                default: begin
                    state <= C_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_det_sched.sv
// tb/tb_seq_det_sched.sv - directed bench: three detector flavours driven by shared lane stimulus
module tb_seq_det_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req, bit_vld, bit_in, bit_last;

    logic [3:0] gnt_a, gnt_b, gnt_c;
    logic       bit_rdy_a, bit_rdy_b, bit_rdy_c;
    logic       det_a, det_b, det_c;
    logic       done_a, done_b, done_c;
    logic [1:0] done_ch_a, done_ch_b, done_ch_c;
    logic [7:0] done_cnt_a, done_cnt_b;
    logic [1:0] done_cnt_c;
    logic       done_abort_a, done_abort_b, done_abort_c;
    logic       busy_a, busy_b, busy_c;

    int n_vec = 0;
    int n_err = 0;
    int det_a_n, det_b_n, det_c_n;

    always #5 clk = ~clk;

    seq_det_sched #(.NUM_REQ(4), .CNT_W(8), .OVERLAP(0)) dut_a (
        .clk(clk), .rst(rst), .req(req), .bit_vld(bit_vld), .bit_in(bit_in), .bit_last(bit_last),
        .gnt(gnt_a), .bit_rdy(bit_rdy_a), .det(det_a), .done(done_a), .done_ch(done_ch_a),
        .done_cnt(done_cnt_a), .done_abort(done_abort_a), .busy(busy_a));

    seq_det_sched #(.NUM_REQ(4), .CNT_W(8), .OVERLAP(1)) dut_b (
        .clk(clk), .rst(rst), .req(req), .bit_vld(bit_vld), .bit_in(bit_in), .bit_last(bit_last),
        .gnt(gnt_b), .bit_rdy(bit_rdy_b), .det(det_b), .done(done_b), .done_ch(done_ch_b),
        .done_cnt(done_cnt_b), .done_abort(done_abort_b), .busy(busy_b));

    seq_det_sched #(.NUM_REQ(4), .CNT_W(2), .OVERLAP(0)) dut_c (
        .clk(clk), .rst(rst), .req(req), .bit_vld(bit_vld), .bit_in(bit_in), .bit_last(bit_last),
        .gnt(gnt_c), .bit_rdy(bit_rdy_c), .det(det_c), .done(done_c), .done_ch(done_ch_c),
        .done_cnt(done_cnt_c), .done_abort(done_abort_c), .busy(busy_c));

    task automatic tick();
        @(posedge clk);
        #1;
        if (det_a) det_a_n++;
        if (det_b) det_b_n++;
        if (det_c) det_c_n++;
    endtask

    task automatic clear_det();
        det_a_n = 0;
        det_b_n = 0;
        det_c_n = 0;
    endtask

    task automatic send(input int ch, input logic b, input logic last);
        bit_vld      = '0;
        bit_in       = '0;
        bit_last     = '0;
        bit_vld[ch]  = 1'b1;
        bit_in[ch]   = b;
        bit_last[ch] = last;
        tick();
        bit_vld  = '0;
        bit_in   = '0;
        bit_last = '0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        req      = '0;
        bit_vld  = '0;
        bit_in   = '0;
        bit_last = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_vec++;
        if ({gnt_a, bit_rdy_a, det_a, done_a, done_ch_a, done_cnt_a, done_abort_a, busy_a} !== 17'd0)
            begin n_err++; $display("FAIL reset_a: got %h want 0", {gnt_a, bit_rdy_a, det_a, done_a, done_ch_a, done_cnt_a, done_abort_a, busy_a}); end
        n_vec++;
        if ({gnt_b, bit_rdy_b, det_b, done_b, done_ch_b, done_cnt_b, done_abort_b, busy_b,
             gnt_c, bit_rdy_c, det_c, done_c, done_ch_c, done_cnt_c, done_abort_c, busy_c} !== 30'd0)
            begin n_err++; $display("FAIL reset_bc: outputs not all zero"); end
        rst = 1'b0;
    endtask

    task automatic test_single_frame();
        do_reset();
        req = 4'b0001;
        n_vec++;
        if (gnt_a !== 4'b0000) begin n_err++; $display("FAIL sf_pregnt: got %b want 0000", gnt_a); end
        tick();
        n_vec++;
        if ({gnt_a, bit_rdy_a, busy_a} !== 6'b0001_1_1) begin n_err++; $display("FAIL sf_gnt: got %b want 000111", {gnt_a, bit_rdy_a, busy_a}); end
        clear_det();
        send(0, 1'b1, 1'b0);
        send(0, 1'b0, 1'b0);
        // Gap on the granted lane with noise on the others.
        bit_vld = 4'b1110;
        bit_in  = 4'b1110;
        tick();
        bit_vld = '0;
        bit_in  = '0;
        send(0, 1'b1, 1'b0);
        send(0, 1'b0, 1'b0);
        send(0, 1'b1, 1'b1);
        n_vec++;
        if ({done_a, done_ch_a, done_cnt_a, done_abort_a} !== {1'b1, 2'd0, 8'd1, 1'b0})
            begin n_err++; $display("FAIL sf_done_a: got done=%b ch=%0d cnt=%0d ab=%b want 1 0 1 0", done_a, done_ch_a, done_cnt_a, done_abort_a); end
        n_vec++;
        if ({done_b, done_cnt_b} !== {1'b1, 8'd2}) begin n_err++; $display("FAIL sf_done_b: got done=%b cnt=%0d want 1 2", done_b, done_cnt_b); end
        n_vec++;
        if (det_a_n !== 1 || det_b_n !== 2) begin n_err++; $display("FAIL sf_det: got a=%0d b=%0d want a=1 b=2", det_a_n, det_b_n); end
        n_vec++;
        if ({gnt_a, bit_rdy_a, busy_a} !== 6'b0000_0_1) begin n_err++; $display("FAIL sf_donestate: got %b want 000001", {gnt_a, bit_rdy_a, busy_a}); end
        req = '0;
        tick();
        n_vec++;
        if ({done_a, busy_a, done_cnt_a, done_cnt_b} !== {1'b0, 1'b0, 8'd1, 8'd2})
            begin n_err++; $display("FAIL sf_hold: got done=%b busy=%b cnt_a=%0d cnt_b=%0d want 0 0 1 2", done_a, busy_a, done_cnt_a, done_cnt_b); end
    endtask

    task automatic test_saturate();
        do_reset();
        req = 4'b0001;
        tick();
        clear_det();
        for (int k = 0; k < 15; k++) begin
            send(0, (k % 3) != 1, k == 14);
        end
        n_vec++;
        if ({done_c, done_cnt_c} !== {1'b1, 2'd3}) begin n_err++; $display("FAIL sat_cnt_c: got done=%b cnt=%0d want 1 3", done_c, done_cnt_c); end
        n_vec++;
        if (det_c_n !== 5) begin n_err++; $display("FAIL sat_det_c: got %0d want 5", det_c_n); end
        n_vec++;
        if (done_cnt_a !== 8'd5) begin n_err++; $display("FAIL sat_cnt_a: got %0d want 5", done_cnt_a); end
        req = '0;
        tick();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_gnt [5];
        exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        req      = 4'b1111;
        bit_vld  = 4'b1111;
        bit_last = 4'b1111;
        tick();
        for (int f = 0; f < 5; f++) begin
            n_vec++;
            if (gnt_a !== exp_gnt[f]) begin n_err++; $display("FAIL rr_gnt%0d: got %b want %b", f, gnt_a, exp_gnt[f]); end
            tick();
            n_vec++;
            if ({done_a, done_ch_a, gnt_a} !== {1'b1, 2'(f % 4), 4'b0000})
                begin n_err++; $display("FAIL rr_done%0d: got done=%b ch=%0d gnt=%b want 1 %0d 0000", f, done_a, done_ch_a, gnt_a, f % 4); end
            tick();
            tick();
        end
        req      = '0;
        bit_vld  = '0;
        bit_last = '0;
        tick();
        tick();
    endtask

    task automatic test_abort();
        do_reset();
        req = 4'b0100;
        tick();
        n_vec++;
        if (gnt_a !== 4'b0100) begin n_err++; $display("FAIL ab_gnt: got %b want 0100", gnt_a); end
        send(2, 1'b1, 1'b0);
        send(2, 1'b0, 1'b0);
        req = '0;
        tick();
        n_vec++;
        if ({done_a, done_ch_a, done_cnt_a, done_abort_a} !== {1'b1, 2'd2, 8'd0, 1'b1})
            begin n_err++; $display("FAIL ab_done: got done=%b ch=%0d cnt=%0d ab=%b want 1 2 0 1", done_a, done_ch_a, done_cnt_a, done_abort_a); end
        tick();
        req = 4'b0100;
        tick();
        clear_det();
        send(2, 1'b1, 1'b1);
        n_vec++;
        if ({done_a, done_cnt_a, done_abort_a} !== {1'b1, 8'd0, 1'b0} || det_a_n !== 0)
            begin n_err++; $display("FAIL ab_fresh: got done=%b cnt=%0d ab=%b det=%0d want 1 0 0 0", done_a, done_cnt_a, done_abort_a, det_a_n); end
        req = '0;
        tick();
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        req = 4'b1000;
        tick();
        send(3, 1'b1, 1'b0);
        send(3, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        n_vec++;
        if ({gnt_a, bit_rdy_a, busy_a, done_a, det_a} !== 8'd0)
            begin n_err++; $display("FAIL rm_clear: got %b want 00000000", {gnt_a, bit_rdy_a, busy_a, done_a, det_a}); end
        rst = 1'b0;
        req = 4'b0010;
        tick();
        n_vec++;
        if ({gnt_a, done_a} !== {4'b0010, 1'b0}) begin n_err++; $display("FAIL rm_gnt: got gnt=%b done=%b want 0010 0", gnt_a, done_a); end
        send(1, 1'b1, 1'b1);
        n_vec++;
        if ({done_a, done_ch_a, done_cnt_a} !== {1'b1, 2'd1, 8'd0})
            begin n_err++; $display("FAIL rm_done: got done=%b ch=%0d cnt=%0d want 1 1 0", done_a, done_ch_a, done_cnt_a); end
        req = '0;
        tick();
    endtask

    initial begin
        rst      = 1'b1;
        req      = '0;
        bit_vld  = '0;
        bit_in   = '0;
        bit_last = '0;
        clear_det();
        test_reset();
        test_single_frame();
        test_saturate();
        test_round_robin();
        test_abort();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
